// File: rtl/regfile_mp_if.sv
// Register-file bus: two combinational read ports, one write port,
// scoreboard alloc port and the clear-sweep request.
//
// Handshake: o_ready is high only while the file is IDLE. i_we, i_alloc and
// i_clear are accepted on a rising clk edge only when o_ready is high in that
// same cycle; while o_ready is low they are dropped, not held or queued.
// Reads carry no handshake and are valid every cycle.
interface regfile_mp_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   i_rs1;
    logic [AW-1:0]   i_rs2;
    logic [XLEN-1:0] o_rs1_value;
    logic [XLEN-1:0] o_rs2_value;
    logic            o_rs1_busy;
    logic            o_rs2_busy;
    logic            i_we;
    logic [AW-1:0]   i_rd;
    logic [XLEN-1:0] i_data_in;
    logic            i_alloc;
    logic [AW-1:0]   i_alloc_rd;
    logic            i_clear;
    logic            o_ready;

    modport master (
        output i_rs1, i_rs2, i_we, i_rd, i_data_in, i_alloc, i_alloc_rd, i_clear,
        input  o_rs1_value, o_rs2_value, o_rs1_busy, o_rs2_busy, o_ready
    );

    modport slave (
        input  i_rs1, i_rs2, i_we, i_rd, i_data_in, i_alloc, i_alloc_rd, i_clear,
        output o_rs1_value, o_rs2_value, o_rs1_busy, o_rs2_busy, o_ready
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-producer scoreboard and a
// one-register-per-cycle clear sweep. Register 0 is hardwired to zero.
module regfile_mp #(
    parameter int  XLEN = 64,
    parameter int  NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          i_resetn,
    regfile_mp_if.slave   bus,
    output logic          o_dbg_state,
    output logic [AW-1:0] o_dbg_ptr
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_ptr_nxt;

    // Entry 0 has no storage; reads of address 0 are forced to zero.
    logic [XLEN-1:0] r_mem [1:NREG-1];
    logic [NREG-1:1] r_pending;

    logic            w_ready;
    logic            w_wr_commit;
    logic            w_alloc_commit;
    logic            w_rs1_hit;
    logic            w_rs2_hit;

    assign w_ready        = (r_state == S_IDLE);
    assign w_wr_commit    = bus.i_we && w_ready && (bus.i_rd != '0);
    assign w_alloc_commit = bus.i_alloc && w_ready && (bus.i_alloc_rd != '0);

    // A committed write to the addressed register is forwarded and also
    // retires the pending producer in the same cycle.
    assign w_rs1_hit = w_wr_commit && (bus.i_rs1 == bus.i_rd);
    assign w_rs2_hit = w_wr_commit && (bus.i_rs2 == bus.i_rd);

    assign bus.o_ready = w_ready;
    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

    // Read port 1: bypass, then storage, with address 0 reading zero.
    always_comb begin
        bus.o_rs1_value = '0;
        bus.o_rs1_busy  = 1'b0;
        if (bus.i_rs1 != '0) begin
            bus.o_rs1_value = w_rs1_hit ? bus.i_data_in : r_mem[bus.i_rs1];
            bus.o_rs1_busy  = r_pending[bus.i_rs1] && !w_rs1_hit;
        end
    end

    // Read port 2: same structure as port 1, fully independent.
    always_comb begin
        bus.o_rs2_value = '0;
        bus.o_rs2_busy  = 1'b0;
        if (bus.i_rs2 != '0) begin
            bus.o_rs2_value = w_rs2_hit ? bus.i_data_in : r_mem[bus.i_rs2];
            bus.o_rs2_busy  = r_pending[bus.i_rs2] && !w_rs2_hit;
        end
    end

    // FSM next state: IDLE accepts a clear; SWEEP walks ptr from 1 to NREG-1.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (bus.i_clear) begin
                    w_state_nxt = S_SWEEP;
                    w_ptr_nxt   = AW'(1);
                end
            end
            S_SWEEP: begin
                if (r_ptr == AW'(NREG - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = AW'(1);
                end else begin
                    w_ptr_nxt = r_ptr + AW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = AW'(1);
            end
        endcase
    end

    // FSM state register; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
            r_ptr   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Storage and scoreboard: reset clears everything at once, the sweep
    // clears one entry per cycle, otherwise commit writes and allocations.
    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            for (int i = 1; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_pending <= '0;
        end else if (r_state == S_SWEEP) begin
            r_mem[r_ptr]     <= '0;
            r_pending[r_ptr] <= 1'b0;
        end else begin
            if (w_wr_commit) begin
                r_mem[bus.i_rd]     <= bus.i_data_in;
                r_pending[bus.i_rd] <= 1'b0;
            end
            // Placed after the write-clear so a new producer wins.
            if (w_alloc_commit) begin
                r_pending[bus.i_alloc_rd] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Stimulus pushes expected observations into
// exp_q; the monitor pops and compares them at the following falling edge.
// Override XLEN/NREG (e.g. 32/16) to run the same vectors on a smaller file.
module tb_regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    typedef enum int {K_V1, K_V2, K_B1, K_B2, K_RDY, K_PTR, K_ST} chk_e;

    typedef struct {
        chk_e        kind;
        logic [63:0] exp;
        string       name;
    } chk_t;

    logic          clk;
    logic          i_resetn;
    logic          dbg_state;
    logic [AW-1:0] dbg_ptr;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk         (clk),
        .i_resetn    (i_resetn),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_ptr   (dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    chk_t        exp_q[$];
    chk_t        m_item;
    logic [63:0] m_act;
    int          n_pass;
    int          n_total;

    function automatic logic [63:0] mval(logic [63:0] v);
        logic [XLEN-1:0] t;
        t = XLEN'(v);
        return 64'(t);
    endfunction

    function automatic logic [63:0] fillv(int i);
        return mval(64'h0101_0101_0101_0101 * 64'(i) + 64'h10);
    endfunction

    function automatic void expect_(chk_e k, logic [63:0] v, string n);
        chk_t c;
        c.kind = k;
        c.exp  = v;
        c.name = n;
        exp_q.push_back(c);
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_item = exp_q.pop_front();
            case (m_item.kind)
                K_V1:    m_act = 64'(bus.o_rs1_value);
                K_V2:    m_act = 64'(bus.o_rs2_value);
                K_B1:    m_act = 64'(bus.o_rs1_busy);
                K_B2:    m_act = 64'(bus.o_rs2_busy);
                K_RDY:   m_act = 64'(bus.o_ready);
                K_PTR:   m_act = 64'(dbg_ptr);
                default: m_act = 64'(dbg_state);
            endcase
            n_total++;
            if (m_act === m_item.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", m_item.name, m_act, m_item.exp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.i_we      = 1'b0;
        bus.i_alloc   = 1'b0;
        bus.i_clear   = 1'b0;
    endtask

    task automatic set_wr(int rd, logic [63:0] d);
        bus.i_we      = 1'b1;
        bus.i_rd      = AW'(rd);
        bus.i_data_in = XLEN'(d);
    endtask

    task automatic set_alloc(int rd);
        bus.i_alloc    = 1'b1;
        bus.i_alloc_rd = AW'(rd);
    endtask

    task automatic set_rd(int a1, int a2);
        bus.i_rs1 = AW'(a1);
        bus.i_rs2 = AW'(a2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r20;
        int pstop;
        r20   = NREG * 5 / 8;
        pstop = NREG / 4 + 2;
        n_pass  = 0;
        n_total = 0;
        i_resetn = 1'b0;
        idle_in();
        set_rd(0, 0);
        bus.i_rd = '0;
        bus.i_data_in = '0;
        bus.i_alloc_rd = '0;
        tick();
        tick();

        // Reset state
        i_resetn = 1'b1;
        set_rd(5, NREG - 1);
        expect_(K_V1, 0, "rst_rs1_val");
        expect_(K_V2, 0, "rst_rs2_val");
        expect_(K_B1, 0, "rst_rs1_busy");
        expect_(K_B2, 0, "rst_rs2_busy");
        expect_(K_RDY, 1, "rst_ready");
        expect_(K_PTR, 1, "rst_ptr");
        expect_(K_ST, 0, "rst_state");
        tick();

        // Basic write / read, x0 hardwired
        set_rd(0, 0);
        set_wr(5, 64'hDEAD_BEEF);
        expect_(K_V1, 0, "rs1_x0_during_write");
        tick();
        idle_in();
        set_rd(5, 0);
        expect_(K_V1, mval(64'hDEAD_BEEF), "read_x5");
        expect_(K_V2, 0, "read_x0");
        tick();
        set_rd(0, 5);
        set_wr(0, 64'h55);
        expect_(K_V1, 0, "x0_no_bypass");
        tick();
        idle_in();
        expect_(K_V1, 0, "x0_after_write");
        expect_(K_V2, mval(64'hDEAD_BEEF), "x5_unchanged");
        tick();

        // Same-cycle bypass
        set_rd(5, 7);
        set_wr(7, 64'h1234);
        expect_(K_V2, 64'h1234, "bypass_x7");
        expect_(K_B2, 0, "bypass_x7_busy");
        expect_(K_V1, mval(64'hDEAD_BEEF), "bypass_other_port");
        tick();
        idle_in();
        expect_(K_V2, 64'h1234, "x7_committed");
        tick();

        // Scoreboard
        set_rd(3, 0);
        set_alloc(3);
        expect_(K_B1, 0, "alloc_not_yet_busy");
        tick();
        idle_in();
        set_alloc(0);
        expect_(K_B1, 1, "alloc_x3_busy");
        tick();
        idle_in();
        expect_(K_B2, 0, "x0_never_busy");
        tick();
        set_wr(3, 64'hAA);
        expect_(K_B1, 0, "write_clears_busy_comb");
        expect_(K_V1, 64'hAA, "write_x3_bypass");
        tick();
        idle_in();
        expect_(K_B1, 0, "busy_cleared");
        expect_(K_V1, 64'hAA, "x3_committed");
        tick();
        set_wr(3, 64'hBB);
        set_alloc(3);
        expect_(K_V1, 64'hBB, "alloc_wr_bypass");
        tick();
        idle_in();
        expect_(K_B1, 1, "alloc_wr_set_wins");
        expect_(K_V1, 64'hBB, "alloc_wr_data");
        tick();

        // Fill and sweep
        for (int i = 1; i < NREG; i++) begin
            set_wr(i, fillv(i));
            tick();
        end
        idle_in();
        set_rd(1, NREG - 1);
        set_alloc(NREG - 2);
        expect_(K_V1, fillv(1), "fill_x1");
        expect_(K_V2, fillv(NREG - 1), "fill_xlast");
        tick();
        idle_in();
        set_rd(NREG - 2, 0);
        bus.i_clear = 1'b1;
        set_wr(2, 64'h99);
        expect_(K_B1, 1, "pending_before_sweep");
        expect_(K_RDY, 1, "ready_at_clear");
        tick();
        for (int k = 0; k < NREG - 1; k++) begin
            idle_in();
            set_rd(2, NREG - 1);
            if (k == 0) expect_(K_V1, 64'h99, "clear_cycle_write_kept");
            if (k == NREG / 2) begin
                set_rd(1, NREG - 1);
                set_wr(NREG - 1, 64'h77);
                set_alloc(1);
                bus.i_clear = 1'b1;
                expect_(K_V1, 0, "swept_reads_zero");
            end
            expect_(K_V2, fillv(NREG - 1), "sweep_unswept_old");
            expect_(K_RDY, 0, "sweep_not_ready");
            expect_(K_PTR, 64'(k + 1), "sweep_ptr");
            tick();
        end
        idle_in();
        for (int i = 0; i < NREG; i++) begin
            set_rd(i, i);
            if (i == 0) expect_(K_RDY, 1, "ready_after_sweep");
            expect_(K_V1, 0, "after_sweep_val");
            expect_(K_B1, 0, "after_sweep_busy1");
            expect_(K_B2, 0, "after_sweep_busy2");
            tick();
        end

        // Reset aborts a sweep
        set_wr(r20, fillv(r20));
        set_alloc(r20);
        tick();
        idle_in();
        bus.i_clear = 1'b1;
        tick();
        idle_in();
        for (int k = 0; k < pstop; k++) begin
            set_rd(r20, 1);
            expect_(K_V1, fillv(r20), "presweep_val");
            expect_(K_B1, 1, "presweep_busy");
            if (k == pstop - 1) begin
                expect_(K_PTR, 64'(pstop), "abort_ptr");
                i_resetn = 1'b0;
                set_wr(r20, 64'h55);
                set_alloc(1);
            end
            tick();
        end
        i_resetn = 1'b1;
        idle_in();
        expect_(K_V1, 0, "abort_val");
        expect_(K_B1, 0, "abort_busy1");
        expect_(K_B2, 0, "abort_busy2");
        expect_(K_RDY, 1, "abort_ready");
        expect_(K_PTR, 1, "abort_ptr_reset");
        expect_(K_ST, 0, "abort_state");
        tick();
        expect_(K_RDY, 1, "abort_stays_idle");
        tick();

        // Reset dominates clear in idle
        i_resetn = 1'b0;
        bus.i_clear = 1'b1;
        tick();
        i_resetn = 1'b1;
        idle_in();
        expect_(K_RDY, 1, "reset_beats_clear");
        tick();

        tick();
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d expected 0 pending", exp_q.size());
            n_total += exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
